// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_div_unit_pkg: op one-hot bit indices and FSM states for mul_div_unit |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mul_div_unit_pkg;

    localparam int c_op_w    = 7;
    localparam int c_op_mul  = 0;
    localparam int c_op_mulh = 1;
    localparam int c_op_mulhu = 2;
    localparam int c_op_div  = 3;
    localparam int c_op_mod  = 4;
    localparam int c_op_divu = 5;
    localparam int c_op_modu = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC1 = 2'd1,
        ST_DIV   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic op_is_div(input logic [c_op_w-1:0] op);
        return op[c_op_div] | op[c_op_mod] | op[c_op_divu] | op[c_op_modu];
    endfunction

    function automatic logic op_is_signed_div(input logic [c_op_w-1:0] op);
        return op[c_op_div] | op[c_op_mod];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_div_radix2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_div_unit_div_radix2: unsigned restoring divider, one bit per cycle   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mul_div_unit_div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int c_cnt_w = $clog2(WIDTH) + 1;

    logic               r_busy;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_divisor;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_quot_nxt;
    logic [WIDTH-1:0]   w_rem_nxt;

    assign w_shift    = {r_rem, r_quot[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_ge       = ~w_diff[WIDTH];
    assign w_rem_nxt  = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quot_nxt = {r_quot[WIDTH-2:0], w_ge};

    // The final iteration is presented combinationally so the caller can
    // register the result on the same edge that ends the loop.
    assign busy      = r_busy;
    assign done      = r_busy && (r_cnt == c_cnt_w'(1));
    assign quotient  = w_quot_nxt;
    assign remainder = w_rem_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (flush) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy    <= 1'b1;
            r_cnt     <= c_cnt_w'(WIDTH);
            r_quot    <= dividend;
            r_rem     <= '0;
            r_divisor <= divisor;
        end else if (r_busy) begin
            r_quot <= w_quot_nxt;
            r_rem  <= w_rem_nxt;
            r_cnt  <= r_cnt - c_cnt_w'(1);
            if (r_cnt == c_cnt_w'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_div_unit: multi-cycle MUL/MULH/MULHU/DIV/MOD/DIVU/MODU with tags     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_op,
    input  logic [WIDTH-1:0]  in_src1,
    input  logic [WIDTH-1:0]  in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [TAG_W-1:0]  out_tag
);

    state_e              r_state;
    logic [c_op_w-1:0]   r_op;
    logic [WIDTH-1:0]    r_src1;
    logic [WIDTH-1:0]    r_src2;
    logic [TAG_W-1:0]    r_tag;
    logic                r_quot_neg;
    logic                r_rem_neg;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_result;
    logic [TAG_W-1:0]    r_out_tag;

    logic                w_src1_neg;
    logic                w_src2_neg;
    logic [WIDTH-1:0]    w_mag1;
    logic [WIDTH-1:0]    w_mag2;
    logic                w_div_start;
    logic                w_div_done;
    logic                w_unused_div_busy;
    logic [WIDTH-1:0]    w_div_quot;
    logic [WIDTH-1:0]    w_div_rem;
    logic [WIDTH-1:0]    w_quot_fix;
    logic [WIDTH-1:0]    w_rem_fix;
    logic [WIDTH-1:0]    w_div_result;
    logic [2*WIDTH+1:0]  w_mul_a;
    logic [2*WIDTH+1:0]  w_mul_b;
    logic [1:0]          w_unused_prod_hi;
    logic [2*WIDTH-1:0]  w_prod;
    logic [WIDTH-1:0]    w_calc1_result;

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_tag    = r_out_tag;

    // Divider works on magnitudes taken straight from the request so it can
    // start on the accept edge; signs are re-applied when the result lands.
    assign w_src1_neg  = op_is_signed_div(in_op) & in_src1[WIDTH-1];
    assign w_src2_neg  = op_is_signed_div(in_op) & in_src2[WIDTH-1];
    assign w_mag1      = w_src1_neg ? -in_src1 : in_src1;
    assign w_mag2      = w_src2_neg ? -in_src2 : in_src2;
    assign w_div_start = in_ready & in_valid & ~flush & op_is_div(in_op) & (in_src2 != '0);

    mul_div_unit_div_radix2 #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .start     (w_div_start),
        .dividend  (w_mag1),
        .divisor   (w_mag2),
        .busy      (w_unused_div_busy),
        .done      (w_div_done),
        .quotient  (w_div_quot),
        .remainder (w_div_rem)
    );

    assign w_quot_fix   = r_quot_neg ? -w_div_quot : w_div_quot;
    assign w_rem_fix    = r_rem_neg ? -w_div_rem : w_div_rem;
    assign w_div_result = (r_op[c_op_div] | r_op[c_op_divu]) ? w_quot_fix : w_rem_fix;

    // Sign-extending to the full product width lets a plain multiply serve both
    // signed (mulh) and unsigned (mul/mulhu) cases.
    assign w_mul_a = {{(WIDTH+2){r_op[c_op_mulh] & r_src1[WIDTH-1]}}, r_src1};
    assign w_mul_b = {{(WIDTH+2){r_op[c_op_mulh] & r_src2[WIDTH-1]}}, r_src2};
    assign {w_unused_prod_hi, w_prod} = w_mul_a * w_mul_b;

    always_comb begin
        w_calc1_result = '0;
        if (r_op[c_op_mul]) begin
            w_calc1_result = w_prod[WIDTH-1:0];
        end else if (r_op[c_op_mulh] | r_op[c_op_mulhu]) begin
            w_calc1_result = w_prod[2*WIDTH-1:WIDTH];
        end else if (r_op[c_op_div] | r_op[c_op_divu]) begin
            w_calc1_result = '1;
        end else begin
            w_calc1_result = r_src1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_op         <= '0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_tag        <= '0;
            r_quot_neg   <= 1'b0;
            r_rem_neg    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op       <= in_op;
                        r_src1     <= in_src1;
                        r_src2     <= in_src2;
                        r_tag      <= in_tag;
                        r_quot_neg <= w_src1_neg ^ w_src2_neg;
                        r_rem_neg  <= w_src1_neg;
                        r_state    <= w_div_start ? ST_DIV : ST_CALC1;
                    end
                end
                ST_CALC1: begin
                    r_out_result <= w_calc1_result;
                    r_out_tag    <= r_tag;
                    r_out_valid  <= 1'b1;
                    r_state      <= ST_DONE;
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_out_result <= w_div_result;
                        r_out_tag    <= r_tag;
                        r_out_valid  <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mul_div_unit: directed self-checking bench for mul_div_unit           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mul_div_unit;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;

    localparam logic [6:0] c_mul   = 7'b0000001;
    localparam logic [6:0] c_mulh  = 7'b0000010;
    localparam logic [6:0] c_mulhu = 7'b0000100;
    localparam logic [6:0] c_div   = 7'b0001000;
    localparam logic [6:0] c_mod   = 7'b0010000;
    localparam logic [6:0] c_divu  = 7'b0100000;
    localparam logic [6:0] c_modu  = 7'b1000000;

    logic             clk;
    logic             resetn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_op;
    logic [WIDTH-1:0] in_src1;
    logic [WIDTH-1:0] in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a request for one cycle; returns in cycle 1 after the accept.
    task automatic issue(input logic [6:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_tag   = tag;
        step();
        in_valid = 1'b0;
        in_op    = '0;
        in_src1  = '0;
        in_src2  = '0;
        in_tag   = '0;
    endtask

    task automatic take(input string name);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, " in_ready after transfer"}, in_ready, 1);
        chk({name, " out_valid after transfer"}, out_valid, 0);
    endtask

    task automatic run_short(input string name, input logic [6:0] op, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                             input logic [WIDTH-1:0] exp);
        issue(op, a, b, tag);
        chk({name, " cycle1 busy"}, {in_ready, out_valid}, 2'b00);
        step();
        chk({name, " cycle2 out_valid"}, out_valid, 1);
        chk({name, " result"}, out_result, exp);
        chk({name, " tag"}, out_tag, tag);
        take(name);
    endtask

    task automatic run_div(input string name, input logic [6:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                           input logic [WIDTH-1:0] exp);
        logic bad;
        bad = 1'b0;
        issue(op, a, b, tag);
        for (int c = 1; c <= 32; c++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
            step();
        end
        chk({name, " quiet cycles 1..32"}, bad, 0);
        chk({name, " cycle33 out_valid"}, out_valid, 1);
        chk({name, " cycle33 in_ready"}, in_ready, 0);
        chk({name, " result"}, out_result, exp);
        chk({name, " tag"}, out_tag, tag);
        take(name);
    endtask

    initial begin
        logic bad;
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_src1   = '0;
        in_src2   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        step();
        step();
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_result", out_result, 0);
        chk("reset out_tag", out_tag, 0);
        resetn = 1'b1;
        step();

        run_short("mul",   c_mul,   32'h0001_2345, 32'h0001_0000, 5'd1, 32'h2345_0000);
        run_short("mulh",  c_mulh,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000);
        run_short("mulhu", c_mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
        run_short("mulh neg", c_mulh, 32'h8000_0000, 32'h0000_0004, 5'd4, 32'hFFFF_FFFE);

        run_div("div -7/2",  c_div,  32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD);
        run_div("mod -7/2",  c_mod,  32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
        run_div("divu",      c_divu, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h7FFF_FFFC);
        run_div("modu 100/7", c_modu, 32'd100, 32'd7, 5'd8, 32'd2);
        run_div("div 7/-2",  c_div,  32'd7, 32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFD);
        run_div("mod 7/-2",  c_mod,  32'd7, 32'hFFFF_FFFE, 5'd10, 32'd1);
        run_div("div ovf",   c_div,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
        run_div("mod ovf",   c_mod,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000);

        run_short("divu by 0", c_divu, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF);
        run_short("modu by 0", c_modu, 32'd5, 32'd0, 5'd14, 32'd5);
        run_short("div by 0",  c_div,  32'hFFFF_FFF9, 32'd0, 5'd15, 32'hFFFF_FFFF);

        // Backpressure: result held while a second request is offered.
        issue(c_mul, 32'd6, 32'd7, 5'd16);
        step();
        chk("bp out_valid", out_valid, 1);
        bad = 1'b0;
        in_valid = 1'b1;
        in_op    = c_mul;
        in_src1  = 32'd3;
        in_src2  = 32'd3;
        in_tag   = 5'd17;
        for (int c = 0; c < 10; c++) begin
            step();
            if (out_valid !== 1'b1 || out_result !== 32'd42 || out_tag !== 5'd16 || in_ready !== 1'b0)
                bad = 1'b1;
        end
        in_valid = 1'b0;
        chk("bp hold stable", bad, 0);
        take("bp");
        step();
        chk("bp no ghost op", out_valid, 0);
        chk("bp idle", in_ready, 1);

        // Flush during divide iteration 10, then a fresh mul.
        issue(c_divu, 32'd1000, 32'd3, 5'd18);
        for (int c = 1; c < 10; c++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush out_valid", out_valid, 0);
        chk("flush in_ready", in_ready, 1);
        run_short("mul after flush", c_mul, 32'd3, 32'd5, 5'd19, 32'd15);
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid !== 1'b0) bad = 1'b1;
            step();
        end
        chk("flush no stale div", bad, 0);

        // Flush together with a request in IDLE: nothing accepted.
        in_valid = 1'b1;
        in_op    = c_mul;
        in_src1  = 32'd2;
        in_src2  = 32'd2;
        in_tag   = 5'd20;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush idle in_ready", in_ready, 1);
        step();
        chk("flush idle out_valid", out_valid, 0);

        // Asynchronous reset mid-divide.
        issue(c_div, 32'd77, 32'd5, 5'd21);
        for (int c = 0; c < 5; c++) step();
        resetn = 1'b0;
        #1;
        chk("areset in_ready", in_ready, 1);
        chk("areset out_result", out_result, 0);
        chk("areset out_tag", out_tag, 0);
        chk("areset out_valid", out_valid, 0);
        step();
        step();
        resetn = 1'b1;
        step();
        chk("release in_ready", in_ready, 1);
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid !== 1'b0) bad = 1'b1;
            step();
        end
        chk("release no output", bad, 0);
        run_short("mul after reset", c_mul, 32'hFFFF_FFFF, 32'd2, 5'd22, 32'hFFFF_FFFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
